// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle control FSM
// and the shared-ALU/shared-memory datapath.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op_i;
    logic             mem_ready_i;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic             RegDst_o;
    logic             MemtoReg_o;
    logic             RegWrite_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [1:0]       ALUOp_o;
    logic [1:0]       PCSource_o;
    logic             illegal_o;
    logic             buserr_o;
    logic [CNT_W-1:0] instret_o;
    logic [3:0]       state_o;

    modport master (
        input  Op_i,
        input  mem_ready_i,
        output PCWrite_o,
        output PCWriteCond_o,
        output IorD_o,
        output MemRead_o,
        output MemWrite_o,
        output IRWrite_o,
        output RegDst_o,
        output MemtoReg_o,
        output RegWrite_o,
        output ALUSrcA_o,
        output ALUSrcB_o,
        output ALUOp_o,
        output PCSource_o,
        output illegal_o,
        output buserr_o,
        output instret_o,
        output state_o
    );

    modport slave (
        output Op_i,
        output mem_ready_i,
        input  PCWrite_o,
        input  PCWriteCond_o,
        input  IorD_o,
        input  MemRead_o,
        input  MemWrite_o,
        input  IRWrite_o,
        input  RegDst_o,
        input  MemtoReg_o,
        input  RegWrite_o,
        input  ALUSrcA_o,
        input  ALUSrcB_o,
        input  ALUOp_o,
        input  PCSource_o,
        input  illegal_o,
        input  buserr_o,
        input  instret_o,
        input  state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb,
// stalls on memory ready, traps on illegal opcodes and bus timeouts.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int SUPPORT_ORI  = 1,
    parameter int CNT_W        = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_WB_I     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Counter only needs to reach MEM_WAIT_MAX-1; it saturates
    // so a disabled timeout never wraps into a false limit.
    localparam int WCW =
        (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WCW-1:0] WLIM = WCW'(MEM_WAIT_MAX - 1);
    localparam logic [WCW-1:0] WSAT = {WCW{1'b1}};

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             buserr_q, buserr_d;

    logic in_wait;
    logic timeout;
    logic retire;

    assign in_wait = (state_q == S_FETCH)
                  || (state_q == S_MEM_RD)
                  || (state_q == S_MEM_WR);

    // A ready arriving on the limit cycle wins over the timeout.
    assign timeout = (MEM_WAIT_MAX != 0)
                  && in_wait
                  && !bus.mem_ready_i
                  && (wcnt_q == WLIM);

    // State, latched opcode, wait counter, counter and sticky flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wcnt_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wcnt_q    <= wcnt_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            buserr_q  <= buserr_d;
        end
    end

    // Next-state sequencing, trap detection and retire accounting.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        buserr_d  = buserr_q;
        retire    = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                op_d = bus.Op_i;
                case (bus.Op_i)
                    OP_R:    state_d = S_EXEC_R;
                    OP_ADDI: state_d = S_EXEC_I;
                    OP_ORI: begin
                        if (SUPPORT_ORI != 0) begin
                            state_d = S_EXEC_I;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_LW,
                    OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (bus.mem_ready_i) begin
                    state_d = S_WB_MEM;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB_MEM: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WR: begin
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            buserr_d = 1'b1;
        end
    end

    // Wait counter runs only while stalled in a memory state.
    always_comb begin
        wcnt_d = '0;
        if (in_wait && !bus.mem_ready_i && (state_d == state_q)) begin
            if (wcnt_q == WSAT) begin
                wcnt_d = wcnt_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_comb begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        bus.PCWrite_o     = 1'b0;
        bus.PCWriteCond_o = 1'b0;
        bus.IorD_o        = 1'b0;
        bus.MemRead_o     = 1'b0;
        bus.MemWrite_o    = 1'b0;
        bus.IRWrite_o     = 1'b0;
        bus.RegDst_o      = 1'b0;
        bus.MemtoReg_o    = 1'b0;
        bus.RegWrite_o    = 1'b0;
        bus.ALUSrcA_o     = 1'b0;
        bus.ALUSrcB_o     = 2'b00;
        bus.ALUOp_o       = 2'b00;
        bus.PCSource_o    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                bus.MemRead_o = 1'b1;
                bus.ALUSrcB_o = 2'b01;
                bus.IRWrite_o = bus.mem_ready_i;
                bus.PCWrite_o = bus.mem_ready_i;
            end
            S_DECODE: begin
                bus.ALUSrcB_o = 2'b11;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = 2'b10;
            end
            S_MEM_RD: begin
                bus.MemRead_o = 1'b1;
                bus.IorD_o    = 1'b1;
            end
            S_WB_MEM: begin
                bus.RegWrite_o = 1'b1;
                bus.MemtoReg_o = 1'b1;
            end
            S_MEM_WR: begin
                bus.MemWrite_o = 1'b1;
                bus.IorD_o     = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUOp_o   = 2'b11;
            end
            S_WB_R: begin
                bus.RegWrite_o = 1'b1;
                bus.RegDst_o   = 1'b1;
            end
            S_EXEC_I: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = 2'b10;
                if (op_q == OP_ORI) begin
                    bus.ALUOp_o = 2'b10;
                end
            end
            S_WB_I: begin
                bus.RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA_o     = 1'b1;
                bus.ALUOp_o       = 2'b01;
                bus.PCWriteCond_o = 1'b1;
                bus.PCSource_o    = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite_o  = 1'b1;
                bus.PCSource_o = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.illegal_o = illegal_q;
    assign bus.buserr_o  = buserr_q;
    assign bus.instret_o = instret_q;
    assign bus.state_o   = state_q;

endmodule
